video_tx_timing_gen: RTL and testbench
======================================

// Module: video_tx_timing_gen
// PURPOSE
//  Source-side counterpart of the HDMI receive path. Runs on clk25 and regenerates a clean 640x480@60
//  raster: hsync, vsync, de and 24-bit RGB, feeding dvi_encoder_top.
//  Pixels come from a first-word-fall-through (FWFT) pixel FIFO, using a rd_en/empty handshake.
//  Each frame's first pixel carries an SOF tag. When no aligned stream is available, the block
//  drives colour bars, so the TX link never loses timing.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line
//  H_FP       16   horizontal front porch, in clocks
//  H_SYNC     96   hsync width, in clocks
//  H_BP       48   horizontal back porch, in clocks (H_TOTAL = 800)
//  V_ACTIVE   480  active lines per frame
//  V_FP       10   vertical front porch, in lines
//  V_SYNC     2    vsync width, in lines
//  V_BP       33   vertical back porch, in lines (V_TOTAL = 525)
//  SYNC_POL   0    sync polarity during the pulse (0 = active-low)
// PORTS
//  clk25       in   1   pixel clock
//  rstin       in   1   reset, asynchronous, active-high
//  enable      in   1   1 = generate raster; 0 = hold counters at 0, outputs blanked
//  fifo_dout   in   25  {sof, r[7:0], g[7:0], b[7:0]}; FWFT, valid whenever !fifo_empty
//  fifo_empty  in   1   FIFO has no word
//  fifo_rd_en  out  1   pop the head word this cycle (combinational)
//  red         out  8   pixel red (registered)
//  green       out  8   pixel green (registered)
//  blue        out  8   pixel blue (registered)
//  hsync       out  1   registered horizontal sync
//  vsync       out  1   registered vertical sync
//  de          out  1   registered data enable
//  locked      out  1   1 while state == LOCKED
//  underflow_cnt out 16 count of underflow events, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset:
//   - h_cnt = v_cnt = 0, state = PATTERN, underflow_cnt = 0.
//   - de = 0, rgb = 0, hsync = vsync = ~SYNC_POL, locked = 0.
//  Counters:
//   - h_cnt runs 0..H_TOTAL-1 and wraps; v_cnt increments when h_cnt wraps.
//   - v_cnt runs 0..V_TOTAL-1 and wraps.
//   - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
//   - hsync pulses for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//   - vsync pulses for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), applied to whole lines.
//  Latency: every output is registered one cycle after the (h_cnt, v_cnt) it reflects.
//  Frame start: h_cnt == 0 and v_cnt == 0.
//  FSM states:
//   - PATTERN: rgb = 8-bar colour pattern (bar = h_cnt[9:7]; white, yellow, cyan, green,
//     magenta, red, blue, black). Pops FIFO words while the head has sof = 0 (flush).
//     At frame start, if !fifo_empty and sof = 1, go to LOCKED and consume that word as pixel (0,0).
//   - LOCKED: fifo_rd_en = active & !fifo_empty; rgb = fifo_dout[23:0].
//     An active cycle with fifo_empty set is an underflow: rgb = 0, underflow_cnt += 1, go to RESYNC.
//     A popped word with sof = 1 at any position other than (0,0) is also treated as an underflow.
//   - RESYNC: rgb = 0 for active cycles; no pops. At the next frame start, apply the PATTERN
//     entry test (go LOCKED on sof). Otherwise go to PATTERN.
//  Rules:
//   - rgb = 0 whenever de = 0.
//   - fifo_rd_en is never asserted while fifo_empty = 1.
//   - enable 0->1 starts at h_cnt = v_cnt = 0 in PATTERN. enable = 0 forces PATTERN, blanks outputs, rd_en = 0.
//   - rstin mid-frame: outputs go to reset values immediately (async); the raster restarts at (0,0) after release.
//   - underflow_cnt saturates at 16'hFFFF; it is not cleared by enable.
// TESTING
//  T1: reset, enable = 1, FIFO empty, 2 frames -> 420000 clocks per frame.
//      Per line: de high for 640 clocks, hsync low for 96 clocks starting 656 clocks after line start.
//      vsync low on lines 490-491. Bar 0 = FFFFFF, bar 6 = 0000FF. locked = 0.
//  T2: FIFO preloaded with a 640x480 frame, sof on word 0, pixel = {v[7:0], h[7:0], 8'h5A}
//      -> locked = 1 at frame start. rgb = pixel one clock after its counter position; 307200 pops, none extra.
//  T3: 5 garbage words (sof = 0) ahead of the frame -> all 5 popped during PATTERN; lock on the next frame start.
//  T4: in LOCKED, starve the FIFO at line 100, pixel 300 -> underflow_cnt = 1, rgb = 0 for the rest of the frame.
//      Next frame relocks if sof is at the head, else PATTERN.
//  T5: stray sof word at (10,10) -> underflow_cnt increments; RESYNC entered.
//  T6: rstin pulsed at line 200 (asserted between clock edges) -> outputs reset with no clock edge needed.
//      First de after release comes 1 clock after the counters restart at (0,0).

Source files
------------

// File: rtl/video_tx_timing_gen.sv
// Transmit-side raster generator: regenerates 640x480@60 timing and feeds it pixels from an
// FWFT FIFO aligned on SOF-tagged words, falling back to colour bars when no aligned stream exists.
module video_tx_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk25,
    input  logic        rstin,
    input  logic        enable,
    input  logic [24:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        locked,
    output logic [15:0] underflow_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // h counter keeps at least 10 bits so the bar index h[9:7] always exists
    localparam int unsigned HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int unsigned VW = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] HActEnd  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncBeg = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HSyncEnd = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] VActEnd  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncBeg = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VSyncEnd = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] VLast    = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {StPattern, StLocked, StResync} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic [23:0]   rgb_q, rgb_d, bar_rgb;
    logic          de_q, hsync_q, vsync_q;
    logic [15:0]   uf_cnt_q;
    logic          run, active, frame_start, head_sof, head_ready, underflow;
    logic          in_hsync, in_vsync;

    assign run         = enable & ~rstin;
    assign active      = (h_q < HActEnd) && (v_q < VActEnd);
    assign frame_start = (h_q == '0) && (v_q == '0);
    assign head_sof    = fifo_dout[24];
    assign head_ready  = !fifo_empty && head_sof;
    assign in_hsync    = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    assign in_vsync    = (v_q >= VSyncBeg) && (v_q < VSyncEnd);

    always_comb begin
        case (h_q[9:7])
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        underflow  = 1'b0;
        rgb_d      = 24'h0;
        if (!run) begin
            state_d = StPattern;
        end else begin
            unique case (state_q)
                StPattern, StResync: begin
                    if (frame_start && head_ready) begin
                        // SOF word at frame start is pixel (0,0) of the new stream
                        state_d    = StLocked;
                        fifo_rd_en = 1'b1;
                        rgb_d      = fifo_dout[23:0];
                    end else if (state_q == StPattern) begin
                        fifo_rd_en = !fifo_empty && !head_sof;
                        rgb_d      = active ? bar_rgb : 24'h0;
                    end else if (frame_start) begin
                        state_d = StPattern;
                    end
                end
                StLocked: begin
                    if (active) begin
                        fifo_rd_en = !fifo_empty;
                        if (fifo_empty || (head_sof && !frame_start)) begin
                            underflow = 1'b1;
                            state_d   = StResync;
                        end else begin
                            rgb_d = fifo_dout[23:0];
                        end
                    end
                end
                default: state_d = StPattern;
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge rstin) begin
        if (rstin) begin
            h_q <= '0;
            v_q <= '0;
        end else if (!enable) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HLast) begin
            h_q <= '0;
            v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    always_ff @(posedge clk25 or posedge rstin) begin
        if (rstin) begin
            state_q  <= StPattern;
            de_q     <= 1'b0;
            rgb_q    <= 24'h0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            uf_cnt_q <= 16'h0;
        end else begin
            state_q <= state_d;
            de_q    <= enable && active;
            rgb_q   <= rgb_d;
            hsync_q <= (enable && in_hsync) ? SYNC_POL : ~SYNC_POL;
            vsync_q <= (enable && in_vsync) ? SYNC_POL : ~SYNC_POL;
            if (underflow && (uf_cnt_q != 16'hFFFF)) begin
                uf_cnt_q <= uf_cnt_q + 16'd1;
            end
        end
    end

    assign red           = rgb_q[23:16];
    assign green         = rgb_q[15:8];
    assign blue          = rgb_q[7:0];
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign de            = de_q;
    assign locked        = (state_q == StLocked);
    assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_video_tx_timing_gen.sv
// Bench for video_tx_timing_gen: full-width lines, shortened frame height; the bench plays the
// FWFT pixel FIFO and predicts every output from raster position and stream-alignment rules.
module tb_video_tx_timing_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk25 = 1'b0;
    logic        rstin = 1'b0;
    logic        enable = 1'b0;
    logic [24:0] fifo_dout = 25'h0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, de, locked;
    logic [15:0] underflow_cnt;

    video_tx_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk25(clk25), .rstin(rstin), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de), .locked(locked),
        .underflow_cnt(underflow_cnt)
    );

    always #20 clk25 = ~clk25;

    typedef enum int {MPattern, MLocked, MResync} mode_t;

    int          n_cmp = 0, n_bad = 0, n_pops = 0;
    logic [24:0] q[$];
    bit          starve = 1'b0;
    bit          rd_act = 1'b0;
    mode_t       mode = MPattern;
    int          pos = 0;
    int          shown_h = 0, shown_v = 0;
    logic [23:0] e_rgb = 24'h0;
    logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_locked = 1'b0;
    int          e_ucnt = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = starve || (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : 25'h0;
    endtask

    task automatic model_reset();
        pos = 0; mode = MPattern;
        e_de = 1'b0; e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_locked = 1'b0; e_ucnt = 0;
    endtask

    // Compare last edge's outputs, then predict this cycle's pop and next registered outputs.
    task automatic half_neg();
        bit          empty, act, fs, rd, uf;
        logic [24:0] head;
        logic [23:0] pix;
        int          h, v;
        @(negedge clk25);
        check("de", de, e_de);
        check("rgb", {red, green, blue}, e_rgb);
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("locked", locked, e_locked);
        check("underflow_cnt", underflow_cnt, e_ucnt);
        empty = starve || (q.size() == 0);
        head  = (q.size() != 0) ? q[0] : 25'h0;
        rd = 1'b0; uf = 1'b0; pix = 24'h0;
        if (rstin) begin
            model_reset();
        end else if (!enable) begin
            pos = 0; mode = MPattern;
            e_de = 1'b0; e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            h   = pos % HT;
            v   = pos / HT;
            act = (h < HA) && (v < VA);
            fs  = (pos == 0);
            if (mode != MLocked && fs && !empty && head[24]) begin
                rd = 1'b1; pix = head[23:0]; mode = MLocked;
            end else if (mode == MPattern) begin
                rd = !empty && !head[24];
                if (act) pix = bars[h / 128];
            end else if (mode == MResync) begin
                if (fs) mode = MPattern;
            end else if (act) begin
                if (empty) uf = 1'b1;
                else begin
                    rd = 1'b1;
                    if (head[24] && !fs) uf = 1'b1;
                    else pix = head[23:0];
                end
            end
            if (uf) begin
                mode = MResync;
                if (e_ucnt < 65535) e_ucnt++;
            end
            e_de  = act;
            e_rgb = pix;
            e_hs  = !(h >= HA + HF && h < HA + HF + HS);
            e_vs  = !(v >= VA + VF && v < VA + VF + VS);
            shown_h = h; shown_v = v;
            pos = (pos + 1) % FRAME;
        end
        e_locked = (mode == MLocked);
        check("rd_en", fifo_rd_en, rd);
        check("rd_en_while_empty", fifo_rd_en & empty, 1'b0);
        rd_act = fifo_rd_en;
    endtask

    task automatic half_pos();
        @(posedge clk25);
        #1;
        if (rd_act && q.size() != 0) begin
            void'(q.pop_front());
            n_pops++;
        end
        drive_fifo();
    endtask

    task automatic cycle();
        half_neg();
        half_pos();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_to(input int h, input int v);
        int budget;
        budget = 2 * FRAME;
        while (pos != v * HT + h && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL run_to(%0d,%0d) timeout: pos %0d", h, v, pos);
        end
    endtask

    task automatic push_frame(input bit fixed_pix, input int stray);
        logic [23:0] px;
        int          idx;
        for (int v = 0; v < VA; v++) begin
            for (int h = 0; h < HA; h++) begin
                idx = v * HA + h;
                px  = fixed_pix ? {v[7:0], h[7:0], 8'h5A} : 24'($urandom);
                q.push_back({(idx == 0 || idx == stray), px});
            end
        end
    endtask

    initial begin
        int n_de, n_hs, n_vs, n_lk, pops0;
        drive_fifo();
        #2 rstin = 1'b1;
        run(3);
        check("reset_de", de, 1'b0);
        check("reset_rgb", {red, green, blue}, 24'h0);
        check("reset_hsync", hsync, 1'b1);
        check("reset_vsync", vsync, 1'b1);
        check("reset_locked", locked, 1'b0);
        check("reset_ucnt", underflow_cnt, 16'h0);
        rstin = 1'b0;
        run(2);

        // Free-running colour bars with an empty FIFO
        enable = 1'b1;
        n_de = 0; n_hs = 0; n_vs = 0; n_lk = 0;
        repeat (2 * FRAME) begin
            cycle();
            if (de) n_de++;
            if (!hsync) n_hs++;
            if (!vsync) n_vs++;
            if (locked) n_lk++;
            if (shown_v == 0 && shown_h == 0) check("bar0_white", {red, green, blue}, 24'hFFFFFF);
            if (shown_v == 1 && shown_h == 200) check("bar1_yellow", {red, green, blue}, 24'hFFFF00);
            if (shown_v == 2 && shown_h == 600) check("bar4_magenta", {red, green, blue}, 24'hFF00FF);
            if (shown_v == 1 && shown_h == 640) check("hblank_de", de, 1'b0);
            if (shown_v == 1 && shown_h == 655) check("hsync_before", hsync, 1'b1);
            if (shown_v == 1 && shown_h == 656) check("hsync_start", hsync, 1'b0);
            if (shown_v == 1 && shown_h == 752) check("hsync_end", hsync, 1'b1);
        end
        check("t1_de_count", n_de, 2 * HA * VA);
        check("t1_hsync_count", n_hs, 2 * VT * HS);
        check("t1_vsync_count", n_vs, 2 * VS * HT);
        check("t1_locked_count", n_lk, 0);
        check("t1_pops", n_pops, 0);

        // Preloaded aligned frame locks at frame start and drains exactly one frame
        push_frame(1'b1, -1);
        drive_fifo();
        pops0 = n_pops;
        repeat (FRAME) begin
            cycle();
            if (shown_v == 0 && shown_h == 0) begin
                check("t2_locked", locked, 1'b1);
                check("t2_pix00", {red, green, blue}, 24'h00005A);
            end
            if (shown_v == 1 && shown_h == 3) check("t2_pix13", {red, green, blue}, 24'h01035A);
        end
        check("t2_pops", n_pops - pops0, HA * VA);
        check("t2_fifo_left", q.size(), 0);
        enable = 1'b0;
        run(2);

        // Garbage ahead of the stream is flushed; lock waits for the next frame start
        for (int i = 0; i < 5; i++) q.push_back({1'b0, 24'($urandom)});
        push_frame(1'b0, -1);
        drive_fifo();
        enable = 1'b1;
        run(10);
        check("t3_flushed", q.size(), HA * VA);
        check("t3_not_locked", locked, 1'b0);
        run_to(0, 0);
        run(1);
        check("t3_locked", locked, 1'b1);

        // Starvation mid-frame; next frame start sees leftovers, so bars, then relock
        run_to(300, 1);
        starve = 1'b1;
        drive_fifo();
        run(5);
        starve = 1'b0;
        drive_fifo();
        check("t4_ucnt", underflow_cnt, 16'd1);
        check("t4_unlocked", locked, 1'b0);
        run(1);
        check("t4_rgb_blank", {red, green, blue}, 24'h0);
        push_frame(1'b0, HA + 10);
        run_to(0, 0);
        run(1);
        check("t4_pattern", locked, 1'b0);
        run_to(0, 0);
        run(1);
        check("t4_relock", locked, 1'b1);

        // Stray SOF at (10,1) counts as an underflow; clean stream relocks from resync
        run_to(10, 1);
        run(2);
        check("t5_ucnt", underflow_cnt, 16'd2);
        check("t5_unlocked", locked, 1'b0);
        q.delete();
        push_frame(1'b0, -1);
        drive_fifo();
        run_to(0, 0);
        run(1);
        check("t5_relock", locked, 1'b1);

        // Asynchronous reset mid-frame
        run_to(100, 1);
        half_neg();
        #2 rstin = 1'b1;
        #1;
        check("t6_de", de, 1'b0);
        check("t6_rgb", {red, green, blue}, 24'h0);
        check("t6_hsync", hsync, 1'b1);
        check("t6_locked", locked, 1'b0);
        check("t6_ucnt", underflow_cnt, 16'h0);
        rd_act = 1'b0;
        model_reset();
        half_pos();
        run(3);
        rstin = 1'b0;
        check("t6_de_released", de, 1'b0);
        run(1);
        check("t6_first_de", de, 1'b1);
        check("t6_first_rgb", {red, green, blue}, 24'hFFFFFF);
        run(FRAME);
        check("t6_ucnt_end", underflow_cnt, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
